// File: rtl/serv_ibus_resp_if.sv
// serv_ibus_resp_if: SERV instruction bus (core drives adr/cyc, memory returns rdt/ack)
interface serv_ibus_resp_if;
  logic [31:0] adr;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;
  modport master (output adr, cyc, input rdt, ack);
  modport slave (input adr, cyc, output rdt, ack);
endinterface

// File: rtl/serv_ibus_resp.sv
// serv_ibus_resp: ibus responder serving word reads from internal RAM with wait states and preload port
module serv_ibus_resp #(
  parameter int          AW          = 10,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = "",
  parameter logic [31:0] FAULT_RDT   = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 i_rst,
  serv_ibus_resp_if.slave      ibus,
  input  logic                 i_ld_en,
  input  logic [AW-1:0]        i_ld_adr,
  input  logic [31:0]          i_ld_dat,
  output logic                 o_busy,
  output logic                 o_fault
);
  typedef enum logic [1:0] {IDLE, WAIT, READ, GAP} state_t;
  state_t        state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx;
  logic          oor;
  logic [31:0]   mem [0:(1<<AW)-1];
  logic          unused_adr;
  assign unused_adr = &{1'b0, ibus.adr[1:0]};
  assign o_busy = state != IDLE;
  always_ff @(posedge clk)
    if (i_ld_en) mem[i_ld_adr] <= i_ld_dat;
  always_ff @(posedge clk or posedge i_rst)
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      oor      <= 1'b0;
      ibus.ack <= 1'b0;
      ibus.rdt <= '0;
      o_fault  <= 1'b0;
    end else begin
      ibus.ack <= 1'b0;
      case (state)
        IDLE: if (ibus.cyc) begin
          idx   <= ibus.adr[AW+1:2];
          oor   <= |ibus.adr[31:AW+2];
          cnt   <= 4'(WAIT_STATES);
          state <= WAIT_STATES > 0 ? WAIT : READ;
        end
        WAIT: begin
          cnt   <= cnt - 4'd1;
          state <= !ibus.cyc ? IDLE : cnt == 4'd1 ? READ : WAIT;
        end
        READ: if (ibus.cyc) begin
          ibus.rdt <= oor ? FAULT_RDT : mem[idx];
          ibus.ack <= 1'b1;
          o_fault  <= o_fault | oor;
          state    <= GAP;
        end else state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
